// File: rtl/adder.sv
// WIDTH-bit adder built from a ripple of 4-bit carry-lookahead groups, with a registered copy and flags.
// Optional ADDER_FLAGS_EN builds the signed-overflow and zero flags; otherwise they read 0.
module adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             en,
  output logic [WIDTH-1:0] Sum_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q
);

  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] gen_bit;
  logic [WIDTH-1:0] prop_bit;
  logic [NGRP:0]    c_grp;
  logic             carry_out;

  assign gen_bit  = in_1 & in_2;
  assign prop_bit = in_1 ^ in_2;
  assign c_grp[0] = 1'b0;

  genvar k;
  generate
    for (k = 0; k < NGRP; k++) begin : g_cla
      logic [GROUP-1:0] gg;
      logic [GROUP-1:0] pp;
      logic [GROUP-1:0] cin;
      logic             ci;
      logic             grp_g;
      logic             grp_p;

      assign gg = gen_bit[k*GROUP +: GROUP];
      assign pp = prop_bit[k*GROUP +: GROUP];
      assign ci = c_grp[k];

      // Bit carries inside the group come straight from g/p and the group carry-in.
      assign cin[0] = ci;
      assign cin[1] = gg[0] | (pp[0] & ci);
      assign cin[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      assign cin[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & ci);

      assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p = &pp;

      assign c_grp[k+1] = grp_g | (grp_p & ci);
      assign Sum_out[k*GROUP +: GROUP] = pp ^ cin;
    end
  endgenerate

  assign carry_out = c_grp[NGRP];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum_q   <= Sum_out;
      carry_q <= carry_out;
    end
  end

`ifdef ADDER_FLAGS_EN
  logic ovf_c;
  logic zero_c;

  assign ovf_c  = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (Sum_out[WIDTH-1] != in_1[WIDTH-1]);
  assign zero_c = (Sum_out == '0);

  // Zero flag resets high so it agrees with the cleared sum_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (en) begin
      ovf_q  <= ovf_c;
      zero_q <= zero_c;
    end
  end
`else
  assign ovf_q  = 1'b0;
  assign zero_q = 1'b0;
`endif

endmodule

// File: tb/tb_adder.sv
// Directed-vector bench for adder: combinational sum, registered stage, flags, reset and hold.
module tb_adder;

  logic        clk;
  logic        reset;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        en;
  logic [31:0] Sum_out;
  logic [31:0] sum_q;
  logic        carry_q;
  logic        ovf_q;
  logic        zero_q;

  int n_cmp;
  int n_err;

`ifdef ADDER_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_1   (in_1),
    .in_2   (in_2),
    .en     (en),
    .Sum_out(Sum_out),
    .sum_q  (sum_q),
    .carry_q(carry_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    in_1 = a;
    in_2 = b;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    en    = 1'b0;
    in_1  = 32'h0;
    in_2  = 32'h0;
    #1;
    chk("rst_sum_q", sum_q, 32'h0);
    chk("rst_carry", {31'b0, carry_q}, 32'h0);
    chk("rst_ovf", {31'b0, ovf_q}, 32'h0);
    chk("rst_zero", {31'b0, zero_q}, {31'b0, FLG});

    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;

    apply(32'h0, 32'h0);
    chk("t1_sum", Sum_out, 32'h0);
    step_clk();
    chk("t1_sum_q", sum_q, 32'h0);
    chk("t1_carry", {31'b0, carry_q}, 32'h0);
    chk("t1_zero", {31'b0, zero_q}, {31'b0, FLG});

    apply(32'd10, 32'd15);
    chk("t2_sum_comb", Sum_out, 32'h19);
    step_clk();
    chk("t2_sum_q", sum_q, 32'h19);
    chk("t2_zero", {31'b0, zero_q}, 32'h0);

    apply(32'hFFFF_FFFB, 32'd5);
    chk("t3_sum", Sum_out, 32'h0);
    step_clk();
    chk("t3_carry", {31'b0, carry_q}, 32'h1);
    chk("t3_ovf", {31'b0, ovf_q}, 32'h0);
    chk("t3_zero", {31'b0, zero_q}, {31'b0, FLG});

    apply(32'hFFFF_FF00, 32'h0000_00FF);
    chk("t4_sum", Sum_out, 32'hFFFF_FFFF);
    step_clk();
    chk("t4_carry", {31'b0, carry_q}, 32'h0);
    chk("t4_sum_q", sum_q, 32'hFFFF_FFFF);

    apply(32'h7FFF_FFFF, 32'h1);
    chk("t5_sum", Sum_out, 32'h8000_0000);
    step_clk();
    chk("t5_ovf", {31'b0, ovf_q}, {31'b0, FLG});
    chk("t5_carry", {31'b0, carry_q}, 32'h0);

    apply(32'h8000_0000, 32'h8000_0000);
    chk("negovf_sum", Sum_out, 32'h0);
    step_clk();
    chk("negovf_carry", {31'b0, carry_q}, 32'h1);
    chk("negovf_ovf", {31'b0, ovf_q}, {31'b0, FLG});
    chk("negovf_zero", {31'b0, zero_q}, {31'b0, FLG});

    apply(32'hFFFF_FFFF, 32'h1);
    chk("wrap_sum", Sum_out, 32'h0);
    step_clk();
    chk("wrap_carry", {31'b0, carry_q}, 32'h1);
    chk("wrap_ovf", {31'b0, ovf_q}, 32'h0);

    apply(32'h0000_000F, 32'h1);
    chk("grp_carry_sum", Sum_out, 32'h0000_0010);
    apply(32'h1234_5678, 32'h9ABC_DEF0);
    chk("mixed_sum", Sum_out, 32'hACF1_3568);
    step_clk();
    chk("mixed_sum_q", sum_q, 32'hACF1_3568);
    chk("mixed_carry", {31'b0, carry_q}, 32'h0);

    // Load, then reset between edges.
    apply(32'd10, 32'd15);
    step_clk();
    chk("t6_loaded", sum_q, 32'h19);
    apply(32'd1, 32'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_sum_q", sum_q, 32'h0);
    chk("t6_rst_zero", {31'b0, zero_q}, {31'b0, FLG});
    chk("t6_rst_comb", Sum_out, 32'h3);
    step_clk();
    chk("t6_rst_over_en", sum_q, 32'h0);
    reset = 1'b0;
    en    = 1'b0;
    step_clk();
    step_clk();
    chk("t6_hold_after_rst", sum_q, 32'h0);
    en = 1'b1;
    step_clk();
    chk("t6_reload", sum_q, 32'h3);
    en = 1'b0;
    apply(32'd5, 32'd5);
    chk("t6_hold_comb", Sum_out, 32'hA);
    step_clk();
    chk("t6_hold_q", sum_q, 32'h3);
    chk("t6_hold_zero", {31'b0, zero_q}, 32'h0);

    apply(32'hxxxx_xxxx, 32'h0);
    chk("x_prop", Sum_out, 32'hxxxx_xxxx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
